trap_csr_ctrl: RTL and testbench

TRAP_CSR_CTRL -- requirements
Module: trap_csr_ctrl

---
 rtl/trap_csr_ctrl_pkg.sv | 41 ++++
 rtl/trap_csr_ctrl_csr_alu.sv | 45 ++++
 rtl/trap_csr_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_trap_csr_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_csr_ctrl_pkg.sv
// Shared definitions for the trap/CSR controller and the CSR file it drives:
// operation encodings, controller state encodings, machine-mode CSR
// addresses and trap cause codes.
package trap_csr_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4,
        OP_RSV5  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_RESP  = 2'd2,
        ST_REDIR = 2'd3
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int CAUSE_ILLEGAL_INSN = 2;
    localparam int CAUSE_ECALL_M      = 11;

    function automatic logic is_known_csr(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

    function automatic logic is_csr_op(input op_e op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/trap_csr_ctrl_csr_alu.sv
// csr_alu: combinational read-modify-write for Zicsr instructions.
// Ports:
//   i_op           operation (only CSRRW/CSRRS/CSRRC produce a write)
//   i_operand      rs1 value or zero-extended zimm
//   i_operand_zero rs1 index / zimm field is zero
//   i_old          current CSR value
//   o_wdata        value to write back
//   o_wen          write enable (CSRRS/CSRRC with a zero source do not write)
module csr_alu
    import trap_csr_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_e             i_op,
    input  logic [XLEN-1:0] i_operand,
    input  logic            i_operand_zero,
    input  logic [XLEN-1:0] i_old,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_wen
);

    always_comb begin
        o_wdata = i_old;
        o_wen   = 1'b0;
        case (i_op)
            OP_CSRRW: begin
                o_wdata = i_operand;
                o_wen   = 1'b1;
            end
            OP_CSRRS: begin
                o_wdata = i_old | i_operand;
                o_wen   = ~i_operand_zero;
            end
            OP_CSRRC: begin
                o_wdata = i_old & ~i_operand;
                o_wen   = ~i_operand_zero;
            end
            default: begin
                o_wdata = i_old;
                o_wen   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/trap_csr_ctrl.sv
// trap_csr_ctrl: sequences CSR read-modify-write, ECALL and MRET against an
// external CSR file with a combinational read port.
//
// state | meaning
// IDLE  | ready for an instruction (in_ready_o=1)
// EXEC  | one cycle: CSR read, write / trap pulse to the CSR file
// RESP  | old CSR value on rd_data_o, waiting for out_ready_i
// REDIR | fetch redirect on redir_pc_o, waiting for redir_ready_i
//
// Ports: clk_i, rst_i (sync, active-low); in_valid_i/in_ready_o with op_i,
// pc_i, csr_addr_i, operand_i, operand_zero_i; csr_rdata_i in and
// csr_addr_o/csr_wen_o/csr_wdata_o/is_ecall_o/is_mret_o/mepc_o/mcause_o out
// to the CSR file; out_valid_o/out_ready_i/rd_data_o result; redir_valid_o/
// redir_ready_i/redir_pc_o fetch redirect.
//
// Build option: YSYX_23060251_ILLEGAL_CSR_TRAP_EN makes CSR ops to addresses
// other than mstatus/mtvec/mepc/mcause trap as illegal instructions.
module trap_csr_ctrl
    import trap_csr_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic            operand_zero_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic [11:0]     csr_addr_o,
    output logic            csr_wen_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            is_ecall_o,
    output logic            is_mret_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic            redir_valid_o,
    input  logic            redir_ready_i,
    output logic [XLEN-1:0] redir_pc_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    state_e          r_state;
    op_e             r_op;
    logic [XLEN-1:0] r_pc;
    logic [11:0]     r_csr_addr;
    logic [XLEN-1:0] r_operand;
    logic            r_operand_zero;
    logic            r_illegal;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_redir_valid;
    logic [XLEN-1:0] r_rd_data;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_is_ecall;
    logic            r_is_mret;
    logic [XLEN-1:0] r_mcause;

    op_e             w_op_in;
    logic            w_illegal_in;
    logic            w_trap_in;
    logic            w_exec;
    logic [XLEN-1:0] w_alu_wdata;
    logic            w_alu_wen;

    assign w_op_in = op_e'(op_i);

`ifdef YSYX_23060251_ILLEGAL_CSR_TRAP_EN
    assign w_illegal_in = is_csr_op(w_op_in) && !is_known_csr(csr_addr_i);
`else
    assign w_illegal_in = 1'b0;
`endif

    // An illegal CSR access is raised through the same path as ECALL.
    assign w_trap_in = (w_op_in == OP_ECALL) || w_illegal_in;
    assign w_exec    = (r_state == ST_EXEC);

    csr_alu #(.XLEN(XLEN)) u_csr_alu (
        .i_op           (r_op),
        .i_operand      (r_operand),
        .i_operand_zero (r_operand_zero),
        .i_old          (csr_rdata_i),
        .o_wdata        (w_alu_wdata),
        .o_wen          (w_alu_wen)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_CSRRW;
            r_pc           <= '0;
            r_csr_addr     <= '0;
            r_operand      <= '0;
            r_operand_zero <= 1'b0;
            r_illegal      <= 1'b0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_redir_valid  <= 1'b0;
            r_rd_data      <= '0;
            r_redir_pc     <= '0;
            r_is_ecall     <= 1'b0;
            r_is_mret      <= 1'b0;
            r_mcause       <= '0;
        end else begin
            r_is_ecall <= 1'b0;
            r_is_mret  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid_i && r_in_ready) begin
                        r_op           <= w_op_in;
                        r_pc           <= pc_i;
                        r_operand      <= operand_i;
                        r_operand_zero <= operand_zero_i;
                        r_illegal      <= w_illegal_in;
                        r_in_ready     <= 1'b0;
                        r_state        <= ST_EXEC;
                        // Traps read mtvec and MRET reads mepc instead of the
                        // instruction's own CSR address.
                        if (w_trap_in)
                            r_csr_addr <= CSR_MTVEC;
                        else if (w_op_in == OP_MRET)
                            r_csr_addr <= CSR_MEPC;
                        else
                            r_csr_addr <= csr_addr_i;
                        if (w_trap_in) begin
                            r_is_ecall <= 1'b1;
                            r_mcause   <= w_illegal_in ? XLEN'(CAUSE_ILLEGAL_INSN)
                                                       : XLEN'(ECALL_CAUSE);
                        end
                        if (w_op_in == OP_MRET)
                            r_is_mret <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_ECALL || r_illegal) begin
                        r_redir_pc    <= csr_rdata_i & ALIGN_MASK;
                        r_redir_valid <= 1'b1;
                        r_state       <= ST_REDIR;
                    end else if (r_op == OP_MRET) begin
                        r_redir_pc    <= csr_rdata_i;
                        r_redir_valid <= 1'b1;
                        r_state       <= ST_REDIR;
                    end else begin
                        r_rd_data   <= is_csr_op(r_op) ? csr_rdata_i : '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_REDIR: begin
                    if (redir_ready_i) begin
                        r_redir_valid <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pulses are qualified with rst_i so a reset landing on the EXEC cycle
    // cannot commit a write or trap at the same edge that abandons it.
    assign csr_wen_o     = w_exec && w_alu_wen && !r_illegal && rst_i;
    assign csr_wdata_o   = w_exec ? w_alu_wdata : '0;
    assign is_ecall_o    = r_is_ecall && rst_i;
    assign is_mret_o     = r_is_mret && rst_i;
    assign csr_addr_o    = r_csr_addr;
    assign mepc_o        = r_pc;
    assign mcause_o      = r_mcause;
    assign in_ready_o    = r_in_ready;
    assign out_valid_o   = r_out_valid;
    assign rd_data_o     = r_rd_data;
    assign redir_valid_o = r_redir_valid;
    assign redir_pc_o    = r_redir_pc;

endmodule

// File: tb/tb_trap_csr_ctrl.sv
module tb_trap_csr_ctrl;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] pc_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] operand_i;
    logic            operand_zero_i;
    logic [XLEN-1:0] csr_rdata_i;
    logic [11:0]     csr_addr_o;
    logic            csr_wen_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            is_ecall_o;
    logic            is_mret_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mcause_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] rd_data_o;
    logic            redir_valid_o;
    logic            redir_ready_i;
    logic [XLEN-1:0] redir_pc_o;

    int checks = 0;
    int failures = 0;

    trap_csr_ctrl #(.XLEN(XLEN), .ECALL_CAUSE(11)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .op_i           (op_i),
        .pc_i           (pc_i),
        .csr_addr_i     (csr_addr_i),
        .operand_i      (operand_i),
        .operand_zero_i (operand_zero_i),
        .csr_rdata_i    (csr_rdata_i),
        .csr_addr_o     (csr_addr_o),
        .csr_wen_o      (csr_wen_o),
        .csr_wdata_o    (csr_wdata_o),
        .is_ecall_o     (is_ecall_o),
        .is_mret_o      (is_mret_o),
        .mepc_o         (mepc_o),
        .mcause_o       (mcause_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .rd_data_o      (rd_data_o),
        .redir_valid_o  (redir_valid_o),
        .redir_ready_i  (redir_ready_i),
        .redir_pc_o     (redir_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one instruction in IDLE and let it be accepted at the next edge.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] pc,
                         input logic [11:0] addr, input logic [XLEN-1:0] opnd,
                         input logic zero);
        in_valid_i     = 1'b1;
        op_i           = op;
        pc_i           = pc;
        csr_addr_i     = addr;
        operand_i      = opnd;
        operand_zero_i = zero;
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; in_valid_i = 1'b0; op_i = '0; pc_i = '0; csr_addr_i = '0;
        operand_i = '0; operand_zero_i = 1'b0; csr_rdata_i = '0;
        out_ready_i = 1'b0; redir_ready_i = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_redir_valid", redir_valid_o, 0);
        chk("rst_wen", csr_wen_o, 0);
        chk("rst_ecall", is_ecall_o, 0);
        chk("rst_mret", is_mret_o, 0);
        chk("rst_rd_data", rd_data_o, 0);
        chk("rst_redir_pc", redir_pc_o, 0);
        chk("rst_mepc", mepc_o, 0);
        chk("rst_mcause", mcause_o, 0);
        chk("rst_wdata", csr_wdata_o, 0);
        chk("rst_addr", csr_addr_o, 0);
        rst_i = 1'b1;
        tick();

        // CSRRW mtvec, response held two cycles before ready
        issue(3'd0, 32'h8000_0000, 12'h305, 32'h8000_0100, 1'b0);
        csr_rdata_i = 32'h0; #1;
        chk("rw_in_ready_exec", in_ready_o, 0);
        chk("rw_addr", csr_addr_o, 12'h305);
        chk("rw_wen", csr_wen_o, 1);
        chk("rw_wdata", csr_wdata_o, 32'h8000_0100);
        tick();
        chk("rw_wen_resp", csr_wen_o, 0);
        chk("rw_out_valid", out_valid_o, 1);
        chk("rw_rd_data", rd_data_o, 32'h0);
        tick();
        chk("rw_out_valid_hold", out_valid_o, 1);
        chk("rw_rd_data_hold", rd_data_o, 32'h0);
        chk("rw_wen_hold", csr_wen_o, 0);
        out_ready_i = 1'b1;
        tick();
        chk("rw_out_valid_done", out_valid_o, 0);
        chk("rw_in_ready_done", in_ready_o, 1);

        // CSRRS mstatus with nonzero source (immediate ready: 3-cycle issue)
        issue(3'd1, 32'h8000_0004, 12'h300, 32'h8, 1'b0);
        csr_rdata_i = 32'h1800; #1;
        chk("rs_wen", csr_wen_o, 1);
        chk("rs_wdata", csr_wdata_o, 32'h1808);
        tick();
        chk("rs_rd_data", rd_data_o, 32'h1800);
        chk("rs_out_valid", out_valid_o, 1);
        tick();
        chk("rs_in_ready_b2b", in_ready_o, 1);

        // CSRRS with zero source: read only
        issue(3'd1, 32'h8000_0008, 12'h300, 32'h8, 1'b1);
        csr_rdata_i = 32'h1800; #1;
        chk("rs0_wen", csr_wen_o, 0);
        tick();
        chk("rs0_wen_resp", csr_wen_o, 0);
        chk("rs0_rd_data", rd_data_o, 32'h1800);
        tick();

        // CSRRC mcause
        issue(3'd2, 32'h8000_000C, 12'h342, 32'h0F, 1'b0);
        csr_rdata_i = 32'hFF; #1;
        chk("rc_wen", csr_wen_o, 1);
        chk("rc_wdata", csr_wdata_o, 32'hF0);
        tick();
        chk("rc_rd_data", rd_data_o, 32'hFF);
        tick();

        // Reserved op: read with no write, rd_data 0
        issue(3'd5, 32'h8000_0010, 12'h300, 32'h1, 1'b0);
        csr_rdata_i = 32'h1234; #1;
        chk("rsv_wen", csr_wen_o, 0);
        chk("rsv_ecall", is_ecall_o, 0);
        tick();
        chk("rsv_out_valid", out_valid_o, 1);
        chk("rsv_rd_data", rd_data_o, 32'h0);
        tick();

        // ECALL
        redir_ready_i = 1'b1;
        issue(3'd3, 32'h8000_0040, 12'h000, 32'h0, 1'b1);
        csr_rdata_i = 32'h8000_0203; #1;
        chk("ecall_pulse", is_ecall_o, 1);
        chk("ecall_mepc", mepc_o, 32'h8000_0040);
        chk("ecall_mcause", mcause_o, 32'd11);
        chk("ecall_addr", csr_addr_o, 12'h305);
        chk("ecall_wen", csr_wen_o, 0);
        tick();
        chk("ecall_pulse_end", is_ecall_o, 0);
        chk("ecall_redir_valid", redir_valid_o, 1);
        chk("ecall_redir_pc", redir_pc_o, 32'h8000_0200);
        chk("ecall_out_valid", out_valid_o, 0);
        tick();
        chk("ecall_idle", in_ready_o, 1);
        chk("ecall_redir_done", redir_valid_o, 0);

        // MRET with redirect back-pressure for 5 cycles
        redir_ready_i = 1'b0;
        issue(3'd4, 32'h8000_0300, 12'h000, 32'h0, 1'b1);
        csr_rdata_i = 32'h8000_0044; #1;
        chk("mret_pulse", is_mret_o, 1);
        chk("mret_addr", csr_addr_o, 12'h341);
        chk("mret_ecall", is_ecall_o, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("mret_redir_valid_hold", redir_valid_o, 1);
            chk("mret_redir_pc_hold", redir_pc_o, 32'h8000_0044);
            chk("mret_in_ready_hold", in_ready_o, 0);
            chk("mret_pulse_hold", is_mret_o, 0);
            tick();
        end
        redir_ready_i = 1'b1;
        chk("mret_redir_valid_last", redir_valid_o, 1);
        tick();
        chk("mret_idle", in_ready_o, 1);
        chk("mret_redir_done", redir_valid_o, 0);

        // CSR op to an address outside the machine-mode trap set
        issue(3'd0, 32'h8000_0050, 12'h7C0, 32'hABCD, 1'b0);
`ifdef YSYX_23060251_ILLEGAL_CSR_TRAP_EN
        csr_rdata_i = 32'h8000_0103; #1;
        chk("ill_wen", csr_wen_o, 0);
        chk("ill_ecall", is_ecall_o, 1);
        chk("ill_mcause", mcause_o, 32'd2);
        chk("ill_mepc", mepc_o, 32'h8000_0050);
        chk("ill_addr", csr_addr_o, 12'h305);
        tick();
        chk("ill_redir_valid", redir_valid_o, 1);
        chk("ill_redir_pc", redir_pc_o, 32'h8000_0100);
        chk("ill_out_valid", out_valid_o, 0);
        tick();
`else
        csr_rdata_i = 32'h55; #1;
        chk("unk_wen", csr_wen_o, 1);
        chk("unk_wdata", csr_wdata_o, 32'hABCD);
        chk("unk_addr", csr_addr_o, 12'h7C0);
        chk("unk_ecall", is_ecall_o, 0);
        tick();
        chk("unk_rd_data", rd_data_o, 32'h55);
        chk("unk_out_valid", out_valid_o, 1);
        tick();
`endif
        chk("unk_idle", in_ready_o, 1);

        // Reset during EXEC of a CSRRW
        issue(3'd0, 32'h8000_0060, 12'h305, 32'h1234, 1'b0);
        rst_i = 1'b0; #1;
        chk("rexec_wen", csr_wen_o, 0);
        tick();
        chk("rexec_in_ready", in_ready_o, 1);
        chk("rexec_out_valid", out_valid_o, 0);
        chk("rexec_wen_after", csr_wen_o, 0);
        rst_i = 1'b1;
        tick();
        chk("rexec_wen_idle", csr_wen_o, 0);

        // Reset during EXEC of an ECALL
        issue(3'd3, 32'h8000_0070, 12'h000, 32'h0, 1'b1);
        rst_i = 1'b0; #1;
        chk("recall_pulse", is_ecall_o, 0);
        tick();
        chk("recall_redir_valid", redir_valid_o, 0);
        chk("recall_in_ready", in_ready_o, 1);
        rst_i = 1'b1;
        tick();

        // Reset during RESP
        out_ready_i = 1'b0;
        issue(3'd1, 32'h8000_0080, 12'h300, 32'h8, 1'b1);
        tick();
        chk("rresp_out_valid_pre", out_valid_o, 1);
        rst_i = 1'b0;
        tick();
        chk("rresp_out_valid", out_valid_o, 0);
        chk("rresp_in_ready", in_ready_o, 1);
        chk("rresp_wen", csr_wen_o, 0);
        rst_i = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
